quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 25 ++
 rtl/quad_sync.sv | 41 ++++
 rtl/quad_decoder.sv | 146 ++++++++++++++
 tb/tb_quad_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder.
// Phase values are written {B,A}; counting up walks 00 -> 01 -> 11 -> 10 -> 00.
package quad_pkg;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Direction of a single-bit phase move: in the forward Gray walk the new
    // B always equals the old A, so any difference means the reverse walk.
    function automatic logic step_dir(input phase_e prev_ph, input phase_e cur_ph);
        logic [1:0] p;
        logic [1:0] c;
        p = prev_ph;
        c = cur_ph;
        return (p[0] ^ c[1]) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

// File: rtl/quad_sync.sv
// Multi-stage synchronizer for the two encoder phases {B,A}.
// SYNC_STAGES (2..4) flops in series; all flops clear to 0 on reset.
module quad_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [1:0] stage_reg  [SYNC_STAGES];
    logic [1:0] stage_next [SYNC_STAGES];

    // Each stage takes the previous stage; stage 0 takes the raw pins.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_next[gi] = din;
            end else begin : g_rest
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    // Shift the phase pair one stage per clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_reg[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_reg[i] <= stage_next[i];
            end
        end
    end

    assign dout = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes enc_a/enc_b, optionally glitch-filters
// them, and turns Gray-code phase moves into step/direction/position/err.
// Optional feature: define QUAD_GLITCH_FILTER_EN to require the synchronized
// phase to hold for FILTER_LEN cycles before the decoder sees it.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    output logic             step,
    output logic             up_down,
    output logic [WIDTH-1:0] position,
    output logic             err
);

    // Startup counter is sized for the longest possible pipeline.
    localparam int FILL_W = $clog2(SYNC_STAGES + FILTER_LEN + 2);

    logic [1:0] sync_phase;
    logic [1:0] dec_phase;

    quad_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .din  ({enc_b, enc_a}),
        .dout (sync_phase)
    );

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int FCW  = $clog2(FILTER_LEN + 1);
    // Cycles from reset release until the filter output carries real input.
    localparam int FILL = SYNC_STAGES + FILTER_LEN + 1;

    logic [1:0]     hold_reg;
    logic [1:0]     filt_reg;
    logic [FCW-1:0] stable_cnt_reg;

    // Count how long the synchronized phase has held; pass it on once stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg       <= 2'b00;
            filt_reg       <= 2'b00;
            stable_cnt_reg <= '0;
        end else begin
            if (sync_phase != hold_reg) begin
                hold_reg       <= sync_phase;
                stable_cnt_reg <= FCW'(1);
            end else if (stable_cnt_reg < FCW'(FILTER_LEN)) begin
                stable_cnt_reg <= stable_cnt_reg + FCW'(1);
            end
            if (stable_cnt_reg >= FCW'(FILTER_LEN)) begin
                filt_reg <= hold_reg;
            end
        end
    end

    assign dec_phase = filt_reg;
`else
    // Cycles from reset release until the decoder input carries real input.
    localparam int FILL = SYNC_STAGES + 1;

    logic [1:0] cur_reg;

    // Register the synchronized phase so the decode compare sees a clean flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_reg <= 2'b00;
        end else begin
            cur_reg <= sync_phase;
        end
    end

    assign dec_phase = cur_reg;
`endif

    phase_e             prev_phase_reg;
    logic               init_reg;
    logic [FILL_W-1:0]  fill_cnt_reg;
    logic               step_reg;
    logic               err_reg;
    logic               up_down_reg;
    logic [WIDTH-1:0]   position_reg;

    logic [1:0] phase_delta;
    logic       move_dir;

    assign phase_delta = prev_phase_reg ^ dec_phase;
    assign move_dir    = step_dir(prev_phase_reg, phase_e'(dec_phase));

    // Decode: wait for the pipeline to flush its reset zeros, latch the first
    // real phase silently, then classify every change as step or error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_phase_reg <= PH_00;
            init_reg       <= 1'b1;
            fill_cnt_reg   <= '0;
            step_reg       <= 1'b0;
            err_reg        <= 1'b0;
            up_down_reg    <= DIR_UP;
            position_reg   <= '0;
        end else begin
            step_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (init_reg) begin
                if (fill_cnt_reg == FILL_W'(FILL)) begin
                    prev_phase_reg <= phase_e'(dec_phase);
                    init_reg       <= 1'b0;
                end else begin
                    fill_cnt_reg <= fill_cnt_reg + FILL_W'(1);
                end
            end else if (phase_delta == 2'b11) begin
                // Both phases moved: direction unknown, resync only.
                err_reg        <= 1'b1;
                prev_phase_reg <= phase_e'(dec_phase);
            end else if (phase_delta != 2'b00) begin
                step_reg       <= 1'b1;
                up_down_reg    <= move_dir;
                prev_phase_reg <= phase_e'(dec_phase);
                if (move_dir == DIR_UP) begin
                    position_reg <= position_reg + WIDTH'(1);
                end else begin
                    position_reg <= position_reg - WIDTH'(1);
                end
            end
            // Clear wins over a same-edge step; step/up_down still report it.
            if (clr) begin
                position_reg <= '0;
            end
        end
    end

    assign step     = step_reg;
    assign err      = err_reg;
    assign up_down  = up_down_reg;
    assign position = position_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: directed scenarios plus randomized phase walks,
// checked every cycle against a delayed-history reference model.
module tb_quad_decoder;

    localparam int WIDTH = 3;
    localparam int S     = 2;
    localparam int F     = 3;
    localparam int M     = 1 << WIDTH;
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int LAT = S + 1 + F;
`else
    localparam int LAT = S + 1;
`endif

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             enc_a = 1'b0;
    logic             enc_b = 1'b0;
    logic             clr   = 1'b0;
    logic             step;
    logic             up_down;
    logic             err;
    logic [WIDTH-1:0] position;

    always #5 clk = ~clk;

    quad_decoder #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(S),
        .FILTER_LEN (F)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .clr     (clr),
        .step    (step),
        .up_down (up_down),
        .position(position),
        .err     (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: the phase seen before each edge, and the resulting
    // count/direction, derived from Gray-walk index arithmetic.
    logic [1:0] hist [$];
    int         m_pos;
    logic       m_ud;
    int         step_seen;
    int         err_seen;
    bit         glitch_hide = 1'b0;

    function automatic int gidx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gval(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset(input logic [1:0] v);
        hist.delete();
        repeat (LAT + 2) hist.push_back(v);
        m_pos = 0;
        m_ud  = 1'b0;
    endtask

    // One clock: advance the model by one edge and compare all outputs.
    task automatic cycle();
        logic [1:0] nv;
        logic [1:0] pv;
        int         d;
        logic       e_step;
        logic       e_err;
        @(posedge clk);
        #1;
        // A one-cycle pulse never gets through the glitch filter.
        hist.push_back(glitch_hide ? 2'b00 : {enc_b, enc_a});
        nv = hist[hist.size() - 1 - LAT];
        pv = hist[hist.size() - 2 - LAT];
        d  = (gidx(nv) - gidx(pv) + 4) % 4;
        e_step = (d == 1) || (d == 3);
        e_err  = (d == 2);
        if (d == 1) m_pos = (m_pos + 1) % M;
        if (d == 3) m_pos = (m_pos + M - 1) % M;
        if (e_step) m_ud = (d == 3);
        if (clr) m_pos = 0;
        check("step", step, e_step);
        check("err", err, e_err);
        check("up_down", up_down, m_ud);
        check("position", position, m_pos);
        if (step) step_seen++;
        if (err) err_seen++;
        while (hist.size() > LAT + 2) void'(hist.pop_front());
    endtask

    task automatic apply(input logic [1:0] v, input int n, input int clr_at, input string tag);
        {enc_b, enc_a} = v;
        for (int c = 0; c < n; c++) begin
            clr = (c == clr_at);
            cycle();
        end
        clr = 1'b0;
        $display("txn %-10s enc=%b clr_at=%0d pos=%0d up_down=%b", tag, v, clr_at, position, up_down);
    endtask

    task automatic settle();
        repeat (LAT + 1) cycle();
    endtask

    task automatic do_reset(input logic [1:0] v);
        reset = 1'b0;
        clr   = 1'b0;
        {enc_b, enc_a} = v;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_step", step, 0);
            check("rst_err", err, 0);
            check("rst_up_down", up_down, 0);
            check("rst_position", position, 0);
        end
        reset = 1'b1;
        model_reset(v);
        repeat (LAT + 4) cycle();
        $display("txn reset      enc=%b pos=%0d", v, position);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [1:0] cur;
        int         r;
        int         n;
        int         ca;

        // Four forward steps from 00.
        do_reset(2'b00);
        step_seen = 0; err_seen = 0;
        apply(2'b01, 4, -1, "up01");
        apply(2'b11, 4, -1, "up11");
        apply(2'b10, 4, -1, "up10");
        apply(2'b00, 4, -1, "up00");
        settle();
        check("s1_steps", step_seen, 4);
        check("s1_errs", err_seen, 0);
        check("s1_pos", position, 4);
        check("s1_dir", up_down, 0);

        // Wrap below zero.
        apply(2'b00, 1, 0, "clr");
        check("s2_clr", position, 0);
        step_seen = 0;
        apply(2'b10, 4, -1, "down10");
        settle();
        check("s2_steps", step_seen, 1);
        check("s2_dir", up_down, 1);
        check("s2_pos", position, 7);

        // Illegal double move from position 5, then a legal up step.
        apply(2'b10, 1, 0, "clr");
        apply(2'b00, 4, -1, "up00");
        apply(2'b01, 4, -1, "up01");
        apply(2'b11, 4, -1, "up11");
        apply(2'b10, 4, -1, "up10");
        apply(2'b00, 4, -1, "up00");
        settle();
        check("s3_pos5", position, 5);
        step_seen = 0; err_seen = 0;
        apply(2'b11, 4, -1, "double");
        settle();
        check("s3_err_cycles", err_seen, 1);
        check("s3_steps", step_seen, 0);
        check("s3_pos_held", position, 5);
        step_seen = 0;
        apply(2'b10, 4, -1, "up10");
        settle();
        check("s3_up_steps", step_seen, 1);
        check("s3_up_dir", up_down, 0);
        check("s3_up_pos", position, 6);

        // Release reset sitting on 11, then step down.
        step_seen = 0; err_seen = 0;
        do_reset(2'b11);
        check("s4_quiet_steps", step_seen, 0);
        check("s4_quiet_errs", err_seen, 0);
        apply(2'b01, 4, -1, "down01");
        settle();
        check("s4_dir", up_down, 1);
        check("s4_pos", position, 7);

        // Clear on the same edge as an up step.
        apply(2'b11, 4, -1, "up11");
        apply(2'b10, 4, -1, "up10");
        apply(2'b00, 4, -1, "up00");
        apply(2'b01, 4, -1, "up01");
        settle();
        check("s5_pos3", position, 3);
        apply(2'b11, LAT + 1, LAT, "up_clr");
        // apply() has just returned from the edge carrying both step and clr.
        check("s5_step", step, 1);
        check("s5_dir", up_down, 0);
        check("s5_pos", position, 0);
        settle();

        // One-cycle glitch on A from 00.
        apply(2'b10, 4, -1, "up10");
        apply(2'b00, 4, -1, "up00");
        settle();
        step_seen = 0; err_seen = 0;
`ifdef QUAD_GLITCH_FILTER_EN
        glitch_hide = 1'b1;
`endif
        apply(2'b01, 1, -1, "glitch");
        glitch_hide = 1'b0;
        apply(2'b00, LAT + 3, -1, "after");
`ifdef QUAD_GLITCH_FILTER_EN
        check("s6_steps", step_seen, 0);
`else
        check("s6_steps", step_seen, 2);
`endif
        check("s6_errs", err_seen, 0);
        check("s6_pos", position, 2);

        // Randomized walk: mostly legal moves, some doubles, holds and clears.
        cur = 2'b00;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      cur = gval(gidx(cur) + 1);
            else if (r <= 7) cur = gval(gidx(cur) + 3);
            else if (r == 9) cur = gval(gidx(cur) + 2);
            n  = $urandom_range(4, 6);
            ca = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            apply(cur, n, ca, "rand");
        end
        settle();

        // Reset in the middle of a transition still in the pipeline.
        cur = gval(gidx(cur) + 1);
        {enc_b, enc_a} = cur;
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_step", step, 0);
        check("mid_rst_pos", position, 0);
        check("mid_rst_dir", up_down, 0);
        step_seen = 0; err_seen = 0;
        do_reset(cur);
        check("mid_rst_no_step", step_seen, 0);
        check("mid_rst_no_err", err_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
